// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encodings and one-hot grant codes.
package wb_arbiter2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Map a master index onto its one-hot grant code.
    function automatic logic [1:0] gnt_onehot(input logic idx);
        return idx ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/wb_arbiter2_watchdog.sv
// Stall watchdog for wb_arbiter2, built only when WB_ARB_WATCHDOG_EN is
// defined. Counts consecutive stalled strobe cycles and flags expiry on the
// TIMEOUT-th one; an ack in that same cycle suppresses expiry via clr.
`ifdef WB_ARB_WATCHDOG_EN
module wb_arb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic clr,
    output logic expire
);

    localparam int            CW    = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear dominates; otherwise count each armed (stalled) cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (arm) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = arm & ~clr & (cnt_q == LIMIT);

endmodule
`endif

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter in front of the on-chip RAM.
// Grants whole cyc-framed bus cycles round-robin and muxes the granted
// master onto the slave port. Optional stall watchdog: WB_ARB_WATCHDOG_EN.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_arbiter2: TIMEOUT must be >= 2");
    end

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;

    logic g_idx, g_cyc, g_stb, g_we, busy, expire;

    assign g_idx = gnt_q[1];
    assign g_cyc = g_idx ? m1_cyc_i : m0_cyc_i;
    assign g_stb = g_idx ? m1_stb_i : m0_stb_i;
    assign g_we  = g_idx ? m1_we_i  : m0_we_i;
    assign busy  = (state_q == ST_BUSY);

`ifdef WB_ARB_WATCHDOG_EN
    wb_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .arm   (busy & s_stb_o & ~s_ack_i),
        .clr   (~busy | ~s_stb_o | s_ack_i),
        .expire(expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, hold the grant until the owner drops cyc.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d = ST_BUSY;
                    if (m0_cyc_i && m1_cyc_i) begin
                        gnt_d = gnt_onehot(~last_q);
                    end else begin
                        gnt_d = gnt_onehot(m1_cyc_i);
                    end
                end
            end
            ST_BUSY: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                    last_d  = g_idx;
                end else if (expire) begin
                    state_d = ST_ABORT;
                end
            end
`ifdef WB_ARB_WATCHDOG_EN
            ST_ABORT: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                    last_d  = g_idx;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers; last=1 lets m0 win the first tie.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_NONE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Slave side: address/data follow the grant (m0 when idle), control gated to BUSY.
    assign s_adr_o = g_idx ? m1_adr_i : m0_adr_i;
    assign s_dat_o = g_idx ? m1_dat_i : m0_dat_i;
    assign s_sel_o = g_idx ? m1_sel_i : m0_sel_i;
    assign s_we_o  = busy & g_we;
    assign s_cyc_o = busy & g_cyc;
    assign s_stb_o = busy & g_stb;

    // Master side: read data broadcast, ack/err steered only to the owner.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & busy & g_cyc & gnt_q[0];
    assign m1_ack_o = s_ack_i & busy & g_cyc & gnt_q[1];
    assign m0_err_o = expire & gnt_q[0];
    assign m1_err_o = expire & gnt_q[1];
    assign gnt_o    = gnt_q;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with a small RAM slave that acks on the
// second cycle of a held strobe. The stall-abort steps are compiled only
// when WB_ARB_WATCHDOG_EN is defined.
`define CHK(tag, obs, exp) \
    begin \
        n_chk++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_wb_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk, rst;
    logic [31:0]   m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]    m0_sel, m1_sel;
    logic          m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic [31:0]   m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]    gnt_o;

    int n_chk = 0;
    int n_fail = 0;

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM slave: registered ack on the second cycle of a held strobe; stall blocks acks.
    logic [31:0] mem [0:255];
    logic        ack_q = 1'b0;
    logic        stall = 1'b0;

    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && ack_q && s_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (s_sel_o[b]) mem[s_adr_o[9:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
            end
        end
        ack_q <= s_cyc_o & s_stb_o & ~ack_q & ~stall;
    end

    assign s_ack_i = ack_q;
    assign s_dat_i = mem[s_adr_o[9:2]];

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit m, input bit cyc, input bit stb, input bit we,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (m) begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = 4'hF;
        end else begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = 4'hF;
        end
    endtask

    // One single-beat cycle by master m, started from an idle bus; leaves the bus idle.
    task automatic single(input bit m, input bit we, input logic [31:0] adr,
                          input logic [31:0] dat, output logic [31:0] rd);
        int   acks;
        logic a;
        acks = 0;
        rd   = '0;
        drive(m, 1'b1, 1'b1, we, adr, dat);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            a = m ? m1_ack_o : m0_ack_o;
            if (a) begin
                acks++;
                rd = m ? m1_dat_o : m0_dat_o;
            end
            nxt();
            if (a) break;
        end
        drive(m, 1'b0, 1'b0, 1'b0, adr, dat);
        @(negedge clk);
        a = m ? m1_ack_o : m0_ack_o;
        `CHK("single_ack_once", acks, 1)
        `CHK("single_ack_after_drop", a, 1'b0)
        nxt();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] rd;
        bit          act [2];
        int          beat [2];
        int          ncyc [2];
        bit          ackd [2];
        logic [1:0]  grants [8];
        logic [1:0]  prev_gnt;
        int          ng, gap, gap_bad, iso_bad, mem_bad, hold_bad, tmo;
        bit          got;

        // ---- 1: reset held 3 cycles with both masters requesting ----
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            `CHK("rst_s_cyc", s_cyc_o, 1'b0)
            `CHK("rst_gnt", gnt_o, 2'b00)
            `CHK("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000)
            if (i < 2) nxt();
        end
        rst = 1'b0;
        nxt();
        @(negedge clk);
        `CHK("t1_first_gnt_m0", gnt_o, 2'b01)
        `CHK("t1_s_cyc", s_cyc_o, 1'b1)
        `CHK("t1_s_adr", s_adr_o, 32'h10)
        nxt();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        `CHK("t1_ack_ignored_cyc0", m0_ack_o, 1'b0)
        nxt();
        @(negedge clk);
        `CHK("t1_idle_gnt", gnt_o, 2'b00)
        nxt();

        // ---- 2: m0 write then readback ----
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        `CHK("t2_latency_s_cyc", s_cyc_o, 1'b0)
        nxt();
        @(negedge clk);
        `CHK("t2_s_cyc", s_cyc_o, 1'b1)
        `CHK("t2_s_adr", s_adr_o, 32'h100)
        `CHK("t2_s_dat", s_dat_o, 32'hDEADBEEF)
        `CHK("t2_s_sel_we", {s_sel_o, s_we_o}, 5'b11111)
        `CHK("t2_gnt", gnt_o, 2'b01)
        `CHK("t2_no_early_ack", m0_ack_o, 1'b0)
        nxt();
        @(negedge clk);
        `CHK("t2_ack", m0_ack_o, 1'b1)
        nxt();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        `CHK("t2_ack_once", m0_ack_o, 1'b0)
        `CHK("t2_drop_s_cyc", s_cyc_o, 1'b0)
        nxt();
        single(1'b0, 1'b0, 32'h100, 32'h0, rd);
        `CHK("t2_readback", rd, 32'hDEADBEEF)

        // ---- 3: both masters, 4 beats each, re-requesting twice ----
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b1; beat[i] = 0; ncyc[i] = 0;
            drive(bit'(i), 1'b1, 1'b1, 1'b1, 32'h200 + 32'(i) * 32'h100,
                  32'hC0DE0000 | (32'(i) << 12));
        end
        prev_gnt = 2'b00; ng = 0; gap = 0; gap_bad = 0; iso_bad = 0;
        for (int k = 0; k < 300; k++) begin
            if (ncyc[0] == 2 && ncyc[1] == 2 && !act[0] && !act[1]) break;
            @(negedge clk);
            if (gnt_o == 2'b01 && m1_ack_o) iso_bad++;
            if (gnt_o == 2'b10 && m0_ack_o) iso_bad++;
            if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
                if (ng < 8) grants[ng] = gnt_o;
                if (ng > 0 && gap != 1) gap_bad++;
                ng++;
            end
            if (gnt_o == 2'b00) gap++;
            else gap = 0;
            prev_gnt = gnt_o;
            ackd[0] = m0_ack_o;
            ackd[1] = m1_ack_o;
            nxt();
            for (int i = 0; i < 2; i++) begin
                if (act[i] && ackd[i]) begin
                    beat[i]++;
                    if (beat[i] == 4) begin
                        act[i] = 1'b0;
                        ncyc[i]++;
                        drive(bit'(i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                    end else begin
                        drive(bit'(i), 1'b1, 1'b1, 1'b1,
                              32'h200 + 32'(i) * 32'h100 + 32'(ncyc[i]) * 32'h10 + 32'(beat[i]) * 4,
                              32'hC0DE0000 | (32'(i) << 12) | (32'(ncyc[i]) << 8) | 32'(beat[i]));
                    end
                end else if (!act[i] && ncyc[i] < 2) begin
                    act[i] = 1'b1;
                    beat[i] = 0;
                    drive(bit'(i), 1'b1, 1'b1, 1'b1,
                          32'h200 + 32'(i) * 32'h100 + 32'(ncyc[i]) * 32'h10,
                          32'hC0DE0000 | (32'(i) << 12) | (32'(ncyc[i]) << 8));
                end
            end
        end
        @(negedge clk);
        nxt();
        `CHK("t3_all_cycles_done", ncyc[0] + ncyc[1], 4)
        `CHK("t3_grant_count", ng, 4)
        `CHK("t3_order0", grants[0], 2'b01)
        `CHK("t3_order1", grants[1], 2'b10)
        `CHK("t3_order2", grants[2], 2'b01)
        `CHK("t3_order3", grants[3], 2'b10)
        `CHK("t3_one_cycle_gaps", gap_bad, 0)
        `CHK("t3_ack_isolation", iso_bad, 0)
        mem_bad = 0;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++)
                for (int b = 0; b < 4; b++)
                    if (mem[8'h80 + 8'(i * 64 + c * 4 + b)] !==
                        (32'hC0DE0000 | (32'(i) << 12) | (32'(c) << 8) | 32'(b))) mem_bad++;
        `CHK("t3_mem_contents", mem_bad, 0)

        // ---- 4: m1 holds cyc with toggling stb while m0 waits ----
        hold_bad = 0; tmo = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h040, 32'h44440000);
        nxt();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h050, 32'h5555AAAA);
        for (int b = 0; b < 3; b++) begin
            got = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (gnt_o !== 2'b10 || m0_ack_o) hold_bad++;
                got = m1_ack_o;
                nxt();
                if (got) break;
            end
            if (!got) tmo++;
            if (b < 2) begin
                drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h040 + 32'(b) * 4, 32'h44440000 + 32'(b));
                @(negedge clk);
                if (gnt_o !== 2'b10 || m0_ack_o || m1_ack_o) hold_bad++;
                nxt();
                drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h040 + 32'(b + 1) * 4, 32'h44440000 + 32'(b + 1));
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        `CHK("t4_gnt_held_drop_cycle", gnt_o, 2'b10)
        nxt();
        @(negedge clk);
        `CHK("t4_bubble", gnt_o, 2'b00)
        nxt();
        @(negedge clk);
        `CHK("t4_gnt_m0", gnt_o, 2'b01)
        `CHK("t4_s_adr_m0", s_adr_o, 32'h050)
        nxt();
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got = m0_ack_o;
            nxt();
            if (got) break;
        end
        if (!got) tmo++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        nxt();
        `CHK("t4_hold", hold_bad, 0)
        `CHK("t4_timeouts", tmo, 0)
        `CHK("t4_m1_beat0", mem[8'h10], 32'h44440000)
        `CHK("t4_m1_beat2", mem[8'h12], 32'h44440002)
        `CHK("t4_m0_write", mem[8'h14], 32'h5555AAAA)

        // ---- 5: reset in the middle of an m1 beat ----
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0F0, 32'h66666666);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        `CHK("t5_gnt_before_rst", gnt_o, 2'b10)
        `CHK("t5_no_ack_before_rst", m1_ack_o, 1'b0)
        nxt();
        @(negedge clk);
        `CHK("t5_s_cyc_after_rst", s_cyc_o, 1'b0)
        `CHK("t5_ack_after_rst", m1_ack_o, 1'b0)
        `CHK("t5_gnt_after_rst", gnt_o, 2'b00)
        `CHK("t5_no_err", {m0_err_o, m1_err_o}, 2'b00)
        nxt();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        nxt();
        single(1'b1, 1'b1, 32'h0F0, 32'h66666666, rd);
        `CHK("t5_restart_write", mem[8'h3C], 32'h66666666)

`ifdef WB_ARB_WATCHDOG_EN
        // ---- 6: slave never acks, watchdog aborts m0 ----
        begin
            int nbusy, nerr, err_at, after_cyc;
            bit prev_err;
            nbusy = 0; nerr = 0; err_at = -1; after_cyc = -1; prev_err = 1'b0;
            stall = 1'b1;
            drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0A0, 32'h77777777);
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (prev_err) after_cyc = int'(s_cyc_o);
                if (s_cyc_o) nbusy++;
                if (m0_err_o) begin
                    nerr++;
                    err_at = nbusy;
                end
                if (m1_err_o) nerr++;
                prev_err = m0_err_o;
                nxt();
            end
            `CHK("t6_err_once", nerr, 1)
            `CHK("t6_err_cycle", err_at, 8)
            `CHK("t6_s_cyc_after_err", after_cyc, 0)
            `CHK("t6_stalled_cycles", nbusy, 8)
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            nxt();
            @(negedge clk);
            `CHK("t6_idle_after_abort", gnt_o, 2'b00)
            nxt();
            stall = 1'b0;
            single(1'b1, 1'b1, 32'h0B0, 32'h88888888, rd);
            `CHK("t6_m1_after_abort", mem[8'h2C], 32'h88888888)
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
